// File: rtl/float_multiply_seq_pkg.sv
// float_multiply_seq_pkg: shared widths, constants and FSM encoding for the sequential FP multiplier.
package float_multiply_seq_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = MANT_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    typedef enum logic [1:0] {IDLE, MUL, NORM} state_e;
endpackage

// File: rtl/float_multiply_seq_seqmultiplier.sv
// float_multiply_seq_seqmultiplier: iterative shift-add 24x24 significand multiply, one bit per cycle.
module float_multiply_seq_seqmultiplier
    import float_multiply_seq_pkg::*;
(
    input  logic              clk,
    input  logic              res,
    input  logic              load,
    input  logic [SIG_W-1:0]  multiplicand,
    input  logic [SIG_W-1:0]  multiplier,
    output logic [PROD_W-1:0] product,
    output logic              fin
);
    logic [PROD_W-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              active_q, active_d;
    assign fin     = active_q && cnt_q == 5'(SIG_W - 1);
    assign product = acc_q;
    // Shifting the operands instead of indexing by cnt keeps the adder input a plain register.
    always_comb begin
        mcand_d  = load ? PROD_W'(multiplicand) : (active_q ? mcand_q << 1 : mcand_q);
        mplier_d = load ? multiplier : (active_q ? mplier_q >> 1 : mplier_q);
        acc_d    = load ? '0 : ((active_q && mplier_q[0]) ? acc_q + mcand_q : acc_q);
        cnt_d    = (load || fin) ? '0 : (active_q ? cnt_q + 5'd1 : cnt_q);
        active_d = load || (active_q && !fin);
    end
    always_ff @(posedge clk) begin
        if (res) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end
endmodule

// File: rtl/float_multiply_seq.sv
// float_multiply_seq: IEEE-754 single multiplier with start/busy/done, fixed 25-cycle latency.
module float_multiply_seq
    import float_multiply_seq_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Prod
);
    state_e state_q, state_d;
    logic               sign_q, sign_d, spec_q, spec_d, done_q, done_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [31:0]        spec_val_q, spec_val_d, prod_q, prod_d;
    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_nan, sign, accept, fin;
    logic signed [9:0]  exp_sum, exp_n;
    logic [PROD_W-1:0]  acc;
    logic               hi, guard, sticky, rnd, carry;
    logic [MANT_W-1:0]  frac, frac_r;
    logic [31:0]        norm_val;
    assign ea      = A[MANT_W +: EXP_W];
    assign eb      = B[MANT_W +: EXP_W];
    assign fa      = A[MANT_W-1:0];
    assign fb      = B[MANT_W-1:0];
    assign a_zero  = ea == '0;
    assign b_zero  = eb == '0;
    assign a_inf   = ea == EXP_MAX && fa == '0;
    assign b_inf   = eb == EXP_MAX && fb == '0;
    assign a_nan   = ea == EXP_MAX && fa != '0;
    assign b_nan   = eb == EXP_MAX && fb != '0;
    assign is_nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    assign sign    = A[31] ^ B[31];
    assign accept  = state_q == IDLE && start;
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(BIAS);
    float_multiply_seq_seqmultiplier u_core (
        .clk          (clk),
        .res          (res),
        .load         (accept),
        .multiplicand ({1'b1, fa}),
        .multiplier   ({1'b1, fb}),
        .product      (acc),
        .fin          (fin)
    );
    // Normalise off the top product bit, then round-to-nearest-even on guard/sticky.
    always_comb begin
        hi            = acc[PROD_W-1];
        frac          = hi ? acc[46:24] : acc[45:23];
        guard         = hi ? acc[23] : acc[22];
        sticky        = hi ? |acc[22:0] : |acc[21:0];
        rnd           = guard && (sticky || frac[0]);
        {carry, frac_r} = {1'b0, frac} + 24'(rnd);
        exp_n         = exp_q + $signed({9'b0, hi}) + $signed({9'b0, carry});
        norm_val      = spec_q ? spec_val_q
                      : exp_n >= 10'sd255 ? {sign_q, EXP_MAX, 23'h0}
                      : exp_n <= 10'sd0 ? {sign_q, 31'h0}
                      : {sign_q, exp_n[7:0], frac_r};
    end
    always_ff @(posedge clk) begin
        if (res) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (start ? MUL : IDLE)
                : state_q == MUL  ? (fin ? NORM : MUL)
                : IDLE;
    end
    always_comb begin
        busy = state_q != IDLE;
        done = done_q;
        Prod = prod_q;
    end
    always_comb begin
        sign_d     = accept ? sign : sign_q;
        exp_d      = accept ? exp_sum : exp_q;
        spec_d     = accept ? (is_nan || a_inf || b_inf || a_zero || b_zero) : spec_q;
        spec_val_d = !accept ? spec_val_q
                   : is_nan ? QNAN
                   : (a_inf || b_inf) ? {sign, EXP_MAX, 23'h0}
                   : {sign, 31'h0};
        prod_d     = state_q == NORM ? norm_val : prod_q;
        done_d     = state_q == NORM;
    end
    always_ff @(posedge clk) begin
        if (res) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            prod_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            prod_q     <= prod_d;
            done_q     <= done_d;
        end
    end
endmodule
